// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA-style scan generator.
// Keeps a 12-bit horizontal/vertical position and derives syncs, active-area
// coordinates, videoActive and per-line/per-frame event pulses from it.
// Every output is registered from the position being entered, so in any
// cycle the outputs describe the position held in that same cycle.
// The position advances only on clk edges with ce=1; pulses are one clk wide
// regardless of ce, while level outputs hold whenever ce=0.
// Legal configuration: totals <= 4096, porch/sync >= 1,
// 1 <= PRE_LEAD <= min(H_ACTIVE, H_FP+H_SYNC+H_BP).
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int PRE_LEAD  = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] realx,
  output logic [CW-1:0] realy,
  output logic          videoActive,
  output logic          pre_xstart,
  output logic          pre_xend,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries as 12-bit constants so comparisons against the counters stay width-matched.
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] H_PRE_XS   = 12'(H_TOTAL - PRE_LEAD);
  localparam logic [11:0] H_PRE_XE   = 12'(H_ACTIVE - PRE_LEAD);

  logic [11:0] r_hpos;
  logic [11:0] r_vpos;
  logic [11:0] w_hpos_nx;
  logic [11:0] w_vpos_nx;
  logic        w_h_wrap;

  logic          r_hsync;
  logic          r_vsync;
  logic [CW-1:0] r_realx;
  logic [CW-1:0] r_realy;
  logic          r_video_active;
  logic          r_pre_xstart;
  logic          r_pre_xend;
  logic          r_line_start;
  logic          r_frame_start;
  logic [7:0]    r_frame_count;

  // Position that the next ce edge enters; outputs are derived from it so they line up with the counters.
  always_comb begin
    w_h_wrap  = (r_hpos == H_LAST);
    w_hpos_nx = w_h_wrap ? 12'd0 : (r_hpos + 12'd1);
    w_vpos_nx = r_vpos;
    if (w_h_wrap) begin
      w_vpos_nx = (r_vpos == V_LAST) ? 12'd0 : (r_vpos + 12'd1);
    end
  end

  // Position counters; reset parks on the last pixel so the first ce enters (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos <= H_LAST;
      r_vpos <= V_LAST;
    end else if (ce) begin
      r_hpos <= w_hpos_nx;
      r_vpos <= w_vpos_nx;
    end
  end

  // Level outputs: recomputed only when the position moves, so they hold through ce=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync        <= ~HSYNC_POL;
      r_vsync        <= ~VSYNC_POL;
      r_realx        <= '0;
      r_realy        <= '0;
      r_video_active <= 1'b0;
    end else if (ce) begin
      r_hsync        <= (w_hpos_nx >= H_SYNC_BEG && w_hpos_nx < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
      r_vsync        <= (w_vpos_nx >= V_SYNC_BEG && w_vpos_nx < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
      r_realx        <= (w_hpos_nx < H_ACT) ? CW'(w_hpos_nx) : '0;
      r_realy        <= (w_vpos_nx < V_ACT) ? CW'(w_vpos_nx) : '0;
      r_video_active <= (w_hpos_nx < H_ACT) && (w_vpos_nx < V_ACT);
    end
  end

  // Event pulses: set by the ce edge entering the trigger position, cleared on every other clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_pre_xstart  <= 1'b0;
      r_pre_xend    <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_line_start  <= ce && (w_hpos_nx == 12'd0);
      r_frame_start <= ce && (w_hpos_nx == 12'd0) && (w_vpos_nx == 12'd0);
      r_pre_xstart  <= ce && (w_hpos_nx == H_PRE_XS);
      r_pre_xend    <= ce && (w_hpos_nx == H_PRE_XE);
      if (ce && (w_hpos_nx == 12'd0) && (w_vpos_nx == 12'd0)) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign realx       = r_realx;
  assign realy       = r_realy;
  assign videoActive = r_video_active;
  assign pre_xstart  = r_pre_xstart;
  assign pre_xend    = r_pre_xend;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_count = r_frame_count;

endmodule
